// File: rtl/pit_timer.sv
// Programmable interval timer: a prescaler feeding a divider. It emits a
// one-cycle tint pulse every (prer+1)*(divr+1) cycles and latches tpend.
module pit_timer (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic [15:0] din,
  input  logic        pre_wr,
  input  logic        div_wr,
  input  logic        en,
  input  logic        int_ack,
  output logic [15:0] pre_q,
  output logic [15:0] div_q,
  output logic        tint,
  output logic        tpend
);

  logic [15:0] prer_q, prer_d;
  logic [15:0] divr_q, divr_d;
  logic [15:0] pre_cnt_q, pre_cnt_d;
  logic [15:0] div_cnt_q, div_cnt_d;
  logic        tint_q, tint_d;
  logic        tpend_q, tpend_d;
  logic        run;
  logic        any_wr;

  // A divider reload of zero stops the timer entirely.
  assign run    = en && (divr_q != 16'd0);
  assign any_wr = pre_wr || div_wr;

  always_comb begin
    prer_d    = prer_q;
    divr_d    = divr_q;
    pre_cnt_d = pre_cnt_q;
    div_cnt_d = div_cnt_q;
    tint_d    = 1'b0;

    if (any_wr) begin
      // Writes pre-empt counting; an untouched counter simply holds.
      if (pre_wr) begin
        prer_d    = din;
        pre_cnt_d = din;
      end
      if (div_wr) begin
        divr_d    = din;
        div_cnt_d = din;
      end
    end else if (run) begin
      if (pre_cnt_q != 16'd0) begin
        pre_cnt_d = pre_cnt_q - 16'd1;
      end else begin
        pre_cnt_d = prer_q;
        if (div_cnt_q != 16'd0) begin
          div_cnt_d = div_cnt_q - 16'd1;
        end else begin
          div_cnt_d = divr_q;
          tint_d    = 1'b1;
        end
      end
    end
  end

  // A new pulse beats an acknowledge arriving on the same edge.
  always_comb begin
    tpend_d = tpend_q;
    if (tint_d) begin
      tpend_d = 1'b1;
    end else if (int_ack) begin
      tpend_d = 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      prer_q    <= 16'd0;
      divr_q    <= 16'd0;
      pre_cnt_q <= 16'd0;
      div_cnt_q <= 16'd0;
      tint_q    <= 1'b0;
      tpend_q   <= 1'b0;
    end else begin
      prer_q    <= prer_d;
      divr_q    <= divr_d;
      pre_cnt_q <= pre_cnt_d;
      div_cnt_q <= div_cnt_d;
      tint_q    <= tint_d;
      tpend_q   <= tpend_d;
    end
  end

  assign pre_q = pre_cnt_q;
  assign div_q = div_cnt_q;
  assign tint  = tint_q;
  assign tpend = tpend_q;

endmodule

// File: tb/tb_pit_timer.sv
// Scoreboard bench for pit_timer. The reference model treats the timer as
// one linear countdown "pos" of (prer+1)*(divr+1) states per period.
module tb_pit_timer;

  logic        sys_clk;
  logic        reset;
  logic [15:0] din;
  logic        pre_wr;
  logic        div_wr;
  logic        en;
  logic        int_ack;
  logic [15:0] pre_q;
  logic [15:0] div_q;
  logic        tint;
  logic        tpend;

  pit_timer dut (
    .sys_clk (sys_clk),
    .reset   (reset),
    .din     (din),
    .pre_wr  (pre_wr),
    .div_wr  (div_wr),
    .en      (en),
    .int_ack (int_ack),
    .pre_q   (pre_q),
    .div_q   (div_q),
    .tint    (tint),
    .tpend   (tpend)
  );

  typedef struct {
    int pre;
    int div;
    int tint;
    int tpend;
  } exp_t;

  exp_t expQueue[$];
  int   checkCount = 0;
  int   errorCount = 0;

  // Reference model state
  longint mPos   = 0;
  int     mPrer  = 0;
  int     mDivr  = 0;
  int     mTint  = 0;
  int     mTpend = 0;

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic modelStep(input logic r, input logic pw, input logic dw,
                           input int d, input logic e, input logic ack);
    int newTint;
    int p;
    int q;
    newTint = 0;
    if (r) begin
      mPos = 0; mPrer = 0; mDivr = 0; mTint = 0; mTpend = 0;
    end else begin
      if (pw || dw) begin
        p = int'(mPos % longint'(mPrer + 1));
        q = int'(mPos / longint'(mPrer + 1));
        if (pw) begin mPrer = d; p = d; end
        if (dw) begin mDivr = d; q = d; end
        mPos = longint'(q) * longint'(mPrer + 1) + longint'(p);
      end else if (e && mDivr != 0) begin
        if (mPos == 0) begin
          newTint = 1;
          mPos = longint'(mDivr) * longint'(mPrer + 1) + longint'(mPrer);
        end else begin
          mPos = mPos - 1;
        end
      end
      if (newTint == 1) mTpend = 1;
      else if (ack) mTpend = 0;
      mTint = newTint;
    end
  endtask

  // One clock of stimulus; the model's prediction for that edge is queued.
  task automatic applyStimulus(input logic r, input logic pw, input logic dw,
                               input int d, input logic e, input logic ack);
    exp_t x;
    @(negedge sys_clk);
    reset = r; pre_wr = pw; div_wr = dw; din = d[15:0]; en = e; int_ack = ack;
    @(posedge sys_clk);
    modelStep(r, pw, dw, d, e, ack);
    x.pre   = int'(mPos % longint'(mPrer + 1));
    x.div   = int'(mPos / longint'(mPrer + 1));
    x.tint  = mTint;
    x.tpend = mTpend;
    expQueue.push_back(x);
  endtask

  task automatic checkOutput(input string name, input int act, input int req);
    checkCount++;
    if (act != req) begin
      errorCount++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
    end
  endtask

  // Monitor: every edge the DUT presents fresh outputs; compare with the queue.
  initial begin
    exp_t x;
    forever begin
      @(posedge sys_clk);
      #1;
      if (expQueue.size() > 0) begin
        x = expQueue.pop_front();
        checkOutput("pre_q", int'(pre_q), x.pre);
        checkOutput("div_q", int'(div_q), x.div);
        checkOutput("tint",  int'(tint),  x.tint);
        checkOutput("tpend", int'(tpend), x.tpend);
      end
    end
  end

  task automatic idle(input int n, input logic e);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 0, e, 1'b0);
  endtask

  initial begin
    int wait_cycles;
    reset = 1'b1; pre_wr = 1'b0; div_wr = 1'b0; din = 16'd0; en = 1'b0; int_ack = 1'b0;

    $display("[TB] reset state");
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h1234, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    idle(3, 1'b1);

    $display("[TB] basic period prer=1 divr=2");
    applyStimulus(1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 2, 1'b0, 1'b0);
    idle(20, 1'b1);

    $display("[TB] zero divider");
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 5, 1'b1, 1'b0);
    idle(100, 1'b1);

    $display("[TB] fast path prer=0 divr=1");
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0);
    idle(10, 1'b1);

    $display("[TB] hold prer=3 divr=3");
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 3, 1'b1, 1'b0);
    idle(7, 1'b1);
    idle(10, 1'b0);
    idle(20, 1'b1);

    $display("[TB] ack race prer=0 divr=2");
    applyStimulus(1'b0, 1'b1, 1'b1, 2, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) begin
      // Ack on the edge that generates tint, then again the cycle after.
      applyStimulus(1'b0, 1'b0, 1'b0, 0, 1'b1,
                    (mPos == 0 && mDivr != 0) || (mTint == 1));
    end

    $display("[TB] mid-run reset prer=2 divr=4");
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 2, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 4, 1'b1, 1'b0);
    idle(7, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 3, 1'b1, 1'b0);
    idle(20, 1'b1);

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 79) == 0),
                    ($urandom_range(0, 15) == 0),
                    ($urandom_range(0, 15) == 0),
                    (($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 65535))
                                                 : int'($urandom_range(0, 5))),
                    ($urandom_range(0, 7) != 0),
                    ($urandom_range(0, 3) == 0));
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 1, 1'b1, 1'b0);
    idle(10, 1'b1);

    wait_cycles = 0;
    while (expQueue.size() > 0 && wait_cycles < 20) begin
      @(posedge sys_clk);
      wait_cycles++;
    end
    #2;
    checkCount++;
    if (expQueue.size() != 0) begin
      errorCount++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", expQueue.size());
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
